// File: rtl/riscv_pkg.sv
// Shared encodings for the execute stage: ALU ops, forward selects, M-stage control
// payload and multiplier FSM states.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_W     = 2'b01;
  localparam logic [1:0] FWD_M     = 2'b10;
  localparam logic [1:0] FWD_W_DLY = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } ctrl_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add 32x32 -> low-32 multiplier, one multiplier bit per cycle.
// Instantiated by execute_stage only when MUL_UNIT_EN is defined.
module mul_seq
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  ctrl_t           ctrl_in,
  output logic            stall_c,
  output logic            done_c,
  output logic [XLEN-1:0] product,
  output ctrl_t           ctrl_out
);

  mul_state_t state_q, state_d;
  logic [XLEN-1:0]  mcand_q, mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_c;

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) state_q <= MUL_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (start && !flush) begin
          state_d = MUL_BUSY;
          stall_c = 1'b1;
          load_c  = 1'b1;
        end
      end
      MUL_BUSY: begin
        stall_c = 1'b1;
        if (flush)                            state_d = MUL_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))   state_d = MUL_DONE;
      end
      MUL_DONE: begin
        state_d = MUL_IDLE;
        done_c  = !flush;
      end
      default: state_d = MUL_IDLE;
    endcase
    // Reset drops the stall at once, even while E still presents the multiply.
    if (reset) stall_c = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin : datapath
    if (reset) begin
      product  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      ctrl_out <= '0;
    end else if (load_c) begin
      product  <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
      ctrl_out <= ctrl_in;
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) product <= product + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: operand forwarding, ALU, branch resolve and E->M register.
// Define MUL_UNIT_EN to add the sequential multiplier (ALUControlE = 1011).
module execute_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_e,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ResultW_delay,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            stall_e
);

  logic [XLEN-1:0] src_a_e, write_data_e, src_b_e, alu_result;
  logic [4:0]      shamt;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  ctrl_t           mul_ctrl;

  always_comb begin : forward_mux
    case (ForwardAE)
      FWD_W:     src_a_e = ResultW;
      FWD_M:     src_a_e = ALUResultM;
      FWD_W_DLY: src_a_e = ResultW_delay;
      default:   src_a_e = RD1_E;
    endcase
    case (ForwardBE)
      FWD_W:     write_data_e = ResultW;
      FWD_M:     write_data_e = ALUResultM;
      FWD_W_DLY: write_data_e = ResultW_delay;
      default:   write_data_e = RD2_E;
    endcase
  end

  assign src_b_e = ALUSrcE ? Imm_Ext_E : write_data_e;
  assign shamt   = src_b_e[4:0];

  always_comb begin : alu
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD:  alu_result = src_a_e + src_b_e;
      ALU_SUB:  alu_result = src_a_e - src_b_e;
      ALU_AND:  alu_result = src_a_e & src_b_e;
      ALU_OR:   alu_result = src_a_e | src_b_e;
      ALU_XOR:  alu_result = src_a_e ^ src_b_e;
      ALU_SLT:  alu_result = XLEN'($signed(src_a_e) < $signed(src_b_e));
      ALU_SLTU: alu_result = XLEN'(src_a_e < src_b_e);
      ALU_SLL:  alu_result = src_a_e << shamt;
      ALU_SRL:  alu_result = src_a_e >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(src_a_e) >>> shamt);
      ALU_PASS: alu_result = src_b_e;
      default:  alu_result = '0;
    endcase
  end

  assign PCSrcE    = !stall_e && (JumpE || (BranchE && (alu_result == '0)));
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef MUL_UNIT_EN
  ctrl_t ctrl_e;
  assign ctrl_e = '{reg_write: RegWriteE, mem_write: MemWriteE,
                    result_src: ResultSrcE, rd: RD_E};

  mul_seq u_mul (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_e),
    .start    (ALUControlE == ALU_MUL),
    .a        (src_a_e),
    .b        (src_b_e),
    .ctrl_in  (ctrl_e),
    .stall_c  (stall_e),
    .done_c   (mul_done),
    .product  (mul_product),
    .ctrl_out (mul_ctrl)
  );
`else
  assign stall_e     = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_ctrl    = '0;
`endif

  // Flush beats a completing multiply; stalls bubble M but hold its data for forwarding.
  always_ff @(posedge clk or posedge reset) begin : m_reg
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (flush_e) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      RD_M       <= '0;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
    end else if (mul_done) begin
      RegWriteM  <= mul_ctrl.reg_write;
      MemWriteM  <= mul_ctrl.mem_write;
      ResultSrcM <= mul_ctrl.result_src;
      RD_M       <= mul_ctrl.rd;
      ALUResultM <= mul_product;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
    end else if (stall_e) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      RD_M       <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage; multiplier scenarios run when MUL_UNIT_EN is defined.
module tb_execute_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush_e;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW, ResultW_delay;
  logic [4:0]  RD_E;
  logic        RegWriteM, MemWriteM, PCSrcE, stall_e;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;

  execute_stage dut (
    .clk(clk), .reset(reset), .flush_e(flush_e),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ResultW_delay(ResultW_delay),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .stall_e(stall_e)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } m_t;

  m_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic m_t m_now();
    m_t m;
    m = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
    return m;
  endfunction

  task automatic nop();
    flush_e = 0; RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ALUControlE = ALU_ADD; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0;
    PCE = 0; PCPlus4E = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0;
    ResultW = 0; ResultW_delay = 0;
  endtask

  task automatic test_reset();
    m_t obs;
    nop();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    obs = m_now();
    checks++;
    if (obs !== '0 || stall_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got m=%h stall=%b expected m=0 stall=0", obs, stall_e);
    end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    logic [1:0]  fa  [4] = '{2'b01, 2'b00, 2'b11, 2'b00};
    logic [1:0]  fb  [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
    logic        src [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ey  [4] = '{32'd10, 32'd12, 32'd18, 32'd105};
    logic [31:0] ewd [4] = '{32'd3, 32'd7, 32'd9, 32'd3};
    m_t exp, obs;
    for (int i = 0; i < 4; i++) begin
      nop();
      RD1_E = 5; RD2_E = 3; ResultW = 7; ResultW_delay = 9; Imm_Ext_E = 100;
      ForwardAE = fa[i]; ForwardBE = fb[i]; ALUSrcE = src[i];
      RegWriteE = 1; ResultSrcE = 2'b01; RD_E = 5'(i + 1); PCPlus4E = 32'h1000 + 32'(4 * i);
      sb.push_back('{1'b1, 1'b0, 2'b01, 5'(i + 1), ey[i], ewd[i], 32'h1000 + 32'(4 * i)});
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = m_now();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL forward[%0d] got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  fa  [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
    logic [1:0]  fb  [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
    logic        src [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ey  [4] = '{32'd3, 32'd7, 32'd13, 32'd14};
    logic [31:0] ewd [4] = '{32'd2, 32'd2, 32'd2, 32'd13};
    m_t exp, obs;
    for (int i = 0; i < 4; i++) begin
      nop();
      RD1_E = 1; RD2_E = 2; Imm_Ext_E = 4; ResultW_delay = 9; ResultW = 32'hDEAD;
      ForwardAE = fa[i]; ForwardBE = fb[i]; ALUSrcE = src[i];
      RegWriteE = 1; MemWriteE = (i == 3); RD_E = 5'(10 + i); PCPlus4E = 32'h2000 + 32'(i);
      sb.push_back('{1'b1, (i == 3), 2'b00, 5'(10 + i), ey[i], ewd[i], 32'h2000 + 32'(i)});
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = m_now();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_alu();
    logic [3:0]  op [17] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLT,
                             ALU_SLTU, ALU_SLTU, ALU_SLL, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRA,
                             ALU_PASS, 4'b1100, 4'b1111};
    logic [31:0] a  [17] = '{32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                             32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h1,
                             32'h80000000, 32'h80000000, 32'h40000000, 32'h1234, 32'h5, 32'h5};
    logic [31:0] b  [17] = '{32'h1, 32'h1, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                             32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'd31, 32'd33,
                             32'd4, 32'd4, 32'd4, 32'h5678ABCD, 32'h6, 32'h6};
    logic [31:0] y  [17] = '{32'h0, 32'hFFFFFFFF, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00,
                             32'h1, 32'h0, 32'h1, 32'h0, 32'h80000000, 32'h2,
                             32'h08000000, 32'hF8000000, 32'h04000000, 32'h5678ABCD, 32'h0, 32'h0};
    m_t exp, obs;
    for (int i = 0; i < 17; i++) begin
      nop();
      ALUControlE = op[i]; RD1_E = a[i]; RD2_E = b[i]; RegWriteE = 1; RD_E = 5'd1;
      sb.push_back('{1'b1, 1'b0, 2'b00, 5'd1, y[i], b[i], 32'h0});
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = m_now();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL alu[%0d] op=%b got %h expected %h", i, op[i], obs, exp);
      end
    end
`ifndef MUL_UNIT_EN
    nop();
    ALUControlE = ALU_MUL; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 5'd2;
    #1;
    checks++;
    if (stall_e !== 1'b0) begin
      errors++;
      $display("FAIL mul_disabled_stall got %b expected 0", stall_e);
    end
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'h0 || RegWriteM !== 1'b1 || RD_M !== 5'd2) begin
      errors++;
      $display("FAIL mul_disabled got alu=%h rw=%b rd=%0d expected alu=0 rw=1 rd=2",
               ALUResultM, RegWriteM, RD_M);
    end
`endif
  endtask

  task automatic test_branch();
    m_t exp, obs;
    nop();
    BranchE = 1; ALUControlE = ALU_SUB; RD1_E = 4; RD2_E = 4; PCE = 32'h100;
    Imm_Ext_E = 32'h20; PCPlus4E = 32'h104;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      errors++;
      $display("FAIL branch_taken got src=%b tgt=%h expected src=1 tgt=120", PCSrcE, PCTargetE);
    end
    sb.push_back('{1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h4, 32'h104});
    @(posedge clk); #1;
    exp = sb.pop_front();
    obs = m_now();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL branch_m got %h expected %h", obs, exp);
    end
    nop();
    flush_e = 1; RegWriteE = 1; MemWriteE = 1; RD_E = 5'd7; RD1_E = 1; RD2_E = 1;
    @(posedge clk); #1;
    checks++;
    if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || RD_M !== 5'd0) begin
      errors++;
      $display("FAIL flush_bubble got rw=%b mw=%b rd=%0d expected 0 0 0", RegWriteM, MemWriteM, RD_M);
    end
    nop();
    BranchE = 1; ALUControlE = ALU_SUB; RD1_E = 4; RD2_E = 3;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken got %b expected 0", PCSrcE);
    end
    nop();
    JumpE = 1; RD1_E = 4; RD2_E = 3; PCE = 32'h200; Imm_Ext_E = 32'hFFFFFFF0;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1F0) begin
      errors++;
      $display("FAIL jump got src=%b tgt=%h expected src=1 tgt=1f0", PCSrcE, PCTargetE);
    end
    nop();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    m_t obs;
    nop();
    RD1_E = 32'h55; RD2_E = 32'h11; RegWriteE = 1; MemWriteE = 1; RD_E = 5'd3;
    PCPlus4E = 32'h44; ResultSrcE = 2'b10;
    @(posedge clk); #2;
    reset = 1;
    #1;
    obs = m_now();
    checks++;
    if (obs !== '0 || stall_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op got m=%h stall=%b expected m=0 stall=0", obs, stall_e);
    end
    nop();
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
  endtask

`ifdef MUL_UNIT_EN
  task automatic test_mul();
    int stall_cnt = 0, edges = 0, writes = 0;
    m_t exp, obs;
    nop();
    @(posedge clk); #1;
    ALUControlE = ALU_MUL; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 5'd9;
    ResultSrcE = 2'b00; PCPlus4E = 32'h80;
    sb.push_back('{1'b1, 1'b0, 2'b00, 5'd9, 32'd42, 32'd7, 32'h80});
    #1;
    while (stall_e && edges < 60) begin
      stall_cnt++;
      if (RegWriteM) writes++;
      @(posedge clk); edges++; #2;
    end
    @(posedge clk); edges++; #1;
    exp = sb.pop_front();
    obs = m_now();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mul_result got %h expected %h", obs, exp);
    end
    if (RegWriteM) writes++;
    checks++;
    if (stall_cnt != 33 || edges != 34) begin
      errors++;
      $display("FAIL mul_timing got stall=%0d edges=%0d expected stall=33 edges=34", stall_cnt, edges);
    end
    nop();
    repeat (4) begin
      @(posedge clk); #1;
      if (RegWriteM) writes++;
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL mul_single_write got %0d expected 1", writes);
    end
  endtask

  task automatic test_mul_flush();
    int writes = 0, stalls = 0;
    nop();
    ALUControlE = ALU_MUL; RD1_E = 6; RD2_E = 7; RegWriteE = 1; RD_E = 5'd9;
    repeat (10) @(posedge clk);
    #1;
    flush_e = 1;
    @(posedge clk); #1;
    if (RegWriteM) writes++;
    nop();
    #1;
    checks++;
    if (stall_e !== 1'b0) begin
      errors++;
      $display("FAIL mul_flush_stall got %b expected 0", stall_e);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (RegWriteM) writes++;
      if (stall_e) stalls++;
    end
    checks++;
    if (writes != 0 || stalls != 0) begin
      errors++;
      $display("FAIL mul_flush got writes=%0d stalls=%0d expected 0 0", writes, stalls);
    end
  endtask

  task automatic test_mul_reset();
    int writes = 0, stalls = 0;
    m_t obs;
    nop();
    RD1_E = 32'h77; RegWriteE = 1; RD_E = 5'd4; PCPlus4E = 32'h10;
    @(posedge clk); #1;
    ALUControlE = ALU_MUL; RD1_E = 6; RD2_E = 7; RD_E = 5'd9;
    repeat (5) @(posedge clk);
    #2;
    reset = 1;
    #1;
    obs = m_now();
    checks++;
    if (obs !== '0 || stall_e !== 1'b0) begin
      errors++;
      $display("FAIL mul_reset got m=%h stall=%b expected m=0 stall=0", obs, stall_e);
    end
    @(posedge clk); #1;
    nop();
    reset = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (RegWriteM) writes++;
      if (stall_e) stalls++;
    end
    checks++;
    if (writes != 0 || stalls != 0) begin
      errors++;
      $display("FAIL mul_reset_after got writes=%0d stalls=%0d expected 0 0", writes, stalls);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_alu();
    test_branch();
    test_reset_mid_op();
`ifdef MUL_UNIT_EN
    test_mul();
    test_mul_flush();
    test_mul_reset();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
